// File: rtl/fetch_pkg.sv
// Shared types and helpers for the Raisin64 fetch queue.
package fetch_pkg;

  localparam int PARCEL_W = 16;

  // inst_len encoding seen by decode
  typedef enum logic [1:0] {
    LEN_NONE = 2'b00,
    LEN16    = 2'b01,
    LEN32    = 2'b10,
    LEN64    = 2'b11
  } inst_len_e;

  // Parcels occupied by the instruction whose first parcel is p0.
  function automatic logic [2:0] inst_parcels(input logic [PARCEL_W-1:0] p0);
    if (!p0[15])      return 3'd1;
    else if (!p0[14]) return 3'd2;
    else              return 3'd4;
  endfunction

  function automatic inst_len_e parcels_to_len(input logic [2:0] n);
    case (n)
      3'd1:    return LEN16;
      3'd2:    return LEN32;
      default: return LEN64;
    endcase
  endfunction

  // Byte length of an instruction; zero for LEN_NONE.
  function automatic logic [3:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      2'b11:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/parcel_queue.sv
// Circular buffer of 16-bit parcels: variable push with leading skip,
// variable pop, exposes the four oldest parcels. Full/empty come from count.
module parcel_queue import fetch_pkg::*; #(
  parameter  int QDEPTH  = 16,
  parameter  int FETCH_P = 4,
  localparam int PTR_W   = $clog2(QDEPTH),
  localparam int CNT_W   = PTR_W + 1,
  localparam int SKP_W   = $clog2(FETCH_P)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic [FETCH_P-1:0][PARCEL_W-1:0] push_data,
  input  logic [SKP_W-1:0]                 push_skip,
  input  logic [2:0]                       pop_n,
  output logic [3:0][PARCEL_W-1:0]         head,
  output logic [CNT_W-1:0]                 count
);

  logic [QDEPTH-1:0][PARCEL_W-1:0]  mem;
  logic [PTR_W-1:0]                 rd_ptr, wr_ptr;
  logic [CNT_W-1:0]                 push_n;
  logic [FETCH_P-1:0][PARCEL_W-1:0] by_addr;
  logic [QDEPTH-1:0][PTR_W-1:0]     off;
  logic [QDEPTH-1:0][SKP_W-1:0]     sel;

  assign push_n = push ? (CNT_W'(FETCH_P) - CNT_W'(push_skip)) : '0;

  // Memory puts the lowest address in the MSBs; reorder so index == address order.
  for (genvar k = 0; k < FETCH_P; k++) begin : g_addr
    assign by_addr[k] = push_data[FETCH_P-1-k];
  end

  // Each entry's distance past the write pointer picks its source parcel.
  for (genvar e = 0; e < QDEPTH; e++) begin : g_ent
    assign off[e] = PTR_W'(e) - wr_ptr;
    assign sel[e] = SKP_W'(off[e]) + push_skip;
  end

  for (genvar k = 0; k < 4; k++) begin : g_head
    assign head[k] = mem[rd_ptr + PTR_W'(k)];
  end

  // Storage write: entries inside the push window take their parcel.
  always_ff @(posedge clk) begin
    if (push)
      for (int e = 0; e < QDEPTH; e++)
        if ({1'b0, off[e]} < push_n) mem[e] <= by_addr[sel[e]];
  end

  // Pointer and occupancy update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      wr_ptr <= wr_ptr + PTR_W'(push_n);
      count  <= count + push_n - CNT_W'(pop_n);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Raisin64 fetch unit: aligned wide fetches with credit control, parcel
// queue, one variable-length instruction per cycle to decode, redirects.
module fetch_queue import fetch_pkg::*; #(
  parameter int              ADDR_W   = 64,
  parameter int              FETCH_W  = 64,
  parameter int              QDEPTH   = 16,
  parameter int              MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_addr_valid,
  input  logic              imem_addr_ready,
  input  logic [FETCH_W-1:0] imem_data,
  input  logic              imem_data_valid,
  output logic [63:0]       inst_data,
  output logic [1:0]        inst_len,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] next_seq_pc,
  input  logic [ADDR_W-1:0] jump_pc,
  input  logic              do_jump
);

  localparam int FETCH_P = FETCH_W / PARCEL_W;
  localparam int FETCH_B = FETCH_W / 8;
  localparam int SKP_W   = $clog2(FETCH_P);
  localparam int CNT_W   = $clog2(QDEPTH) + 1;
  localparam int OUT_W   = 3;

  function automatic logic [ADDR_W-1:0] align_fetch(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(FETCH_B - 1);
  endfunction

  logic                      started;
  logic [ADDR_W-1:0]         fetch_pc, pc;
  logic [OUT_W-1:0]          outstanding, drop, out_next;
  logic [SKP_W-1:0]          skip;
  logic [CNT_W-1:0]          count;
  logic [3:0][PARCEL_W-1:0]  head;
  logic [2:0]                need, pop_n;
  logic                      credit_ok, req_fire, push, accept;

  // Presentation to decode
  assign need        = inst_parcels(head[0]);
  assign inst_valid  = ~do_jump & (count >= CNT_W'(need));
  assign inst_len    = inst_valid ? parcels_to_len(need) : LEN_NONE;
  assign inst_pc     = pc;
  assign next_seq_pc = pc + ADDR_W'(len_bytes(inst_len));
  assign accept      = inst_valid & inst_ready;
  assign pop_n       = accept ? need : 3'd0;

  // Left-align the instruction and zero everything past its length.
  always_comb begin
    inst_data = '0;
    if (inst_valid)
      case (need)
        3'd1:    inst_data = {head[0], 48'h0};
        3'd2:    inst_data = {head[0], head[1], 32'h0};
        default: inst_data = {head[0], head[1], head[2], head[3]};
      endcase
  end

  // Only issue when the queue has room for every in-flight word plus this one.
  assign credit_ok       = (QDEPTH - int'(count) - FETCH_P * int'(outstanding)) >= FETCH_P;
  assign imem_addr       = fetch_pc;
  assign imem_addr_valid = started & ~do_jump & (outstanding < OUT_W'(MAX_OUT)) & credit_ok;
  assign req_fire        = imem_addr_valid & imem_addr_ready;
  assign push            = imem_data_valid & (drop == '0);
  assign out_next        = outstanding + {2'b0, req_fire} - {2'b0, imem_data_valid};

  parcel_queue #(.QDEPTH(QDEPTH), .FETCH_P(FETCH_P)) u_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (do_jump),
    .push      (push),
    .push_data (imem_data),
    .push_skip (skip),
    .pop_n     (pop_n),
    .head      (head),
    .count     (count)
  );

  // Request/drop bookkeeping and PC tracking; a redirect overrides all of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      fetch_pc    <= align_fetch(RESET_PC);
      skip        <= RESET_PC[SKP_W:1];
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= out_next;
      if (do_jump) begin
        drop     <= out_next;
        fetch_pc <= align_fetch(jump_pc);
        skip     <= jump_pc[SKP_W:1];
        pc       <= jump_pc;
      end else begin
        if (imem_data_valid && drop != '0) drop <= drop - 3'd1;
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(FETCH_B);
        if (push)     skip <= '0;
        if (accept)   pc <= pc + ADDR_W'({need, 1'b0});
      end
    end
  end

endmodule
